// File: rtl/regfile_wb_if.sv
// Write-back / issue / decode bus for the register-file write-port arbiter.
//
// Groups every signal that crosses between the arbiter and the pipeline:
//   ALU requester    : a_valid, a_rd, a_data  -> a_ready
//   Load requester   : m_valid, m_rd, m_data  -> m_ready
//   Issue stage      : issue_valid, issue_rd  -> issue_ready
//   Decode stage     : decode_valid, rs, rt   -> stall
//   Reg-file port    : rd, write_data, reg_write, grant_m
//   Status           : err_underflow
//
// Handshake: a transfer happens in a cycle where valid and ready are both
// high at the rising clock edge. ready is a combinational function of the
// valids and internal state only; a requester must not make valid depend on
// ready, and a requester that is not accepted holds its rd/data stable until
// it is.
//
// Modports: slave = the arbiter, master = the surrounding pipeline.
interface regfile_wb_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2
);
  logic                  a_valid;
  logic [ADDR_WIDTH-1:0] a_rd;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  a_ready;

  logic                  m_valid;
  logic [ADDR_WIDTH-1:0] m_rd;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  logic                  issue_valid;
  logic [ADDR_WIDTH-1:0] issue_rd;
  logic                  issue_ready;

  logic                  decode_valid;
  logic [ADDR_WIDTH-1:0] rs;
  logic [ADDR_WIDTH-1:0] rt;
  logic                  stall;

  logic [ADDR_WIDTH-1:0] rd;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  reg_write;
  logic                  grant_m;
  logic                  err_underflow;

  modport slave (
    input  a_valid, a_rd, a_data,
    input  m_valid, m_rd, m_data,
    input  issue_valid, issue_rd,
    input  decode_valid, rs, rt,
    output a_ready, m_ready, issue_ready, stall,
    output rd, write_data, reg_write, grant_m, err_underflow
  );

  modport master (
    output a_valid, a_rd, a_data,
    output m_valid, m_rd, m_data,
    output issue_valid, issue_rd,
    output decode_valid, rs, rt,
    input  a_ready, m_ready, issue_ready, stall,
    input  rd, write_data, reg_write, grant_m, err_underflow
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Single-write-port scheduler for the CPU register file.
//
// Round-robin arbitration between the ALU (A) and load (M) write-back
// requesters; the winner's destination/data is registered and drives the
// register-file write port for one cycle. A per-register pending-write
// counter (incremented by the issue stage, decremented when the write port
// commits) produces the read-after-write stall for decode.
//
// Ports:
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   bus      : regfile_wb_if.slave (requesters, issue, decode, write port)
//   dbg_last_grant_m_o : round-robin state, 1 = M won the last grant
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2,
  parameter int CNT_WIDTH  = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  regfile_wb_if.slave  bus,
  output logic         dbg_last_grant_m_o
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Round-robin state; reset value M makes A win the first tie.
  logic last_grant_m_q, last_grant_m_d;

  // Registered write port.
  logic                  reg_write_q, reg_write_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  grant_m_q, grant_m_d;

  // Scoreboard.
  logic [CNT_WIDTH-1:0] cnt_q [NUM_REGS];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_REGS];
  logic                 err_q, err_d;
  logic [NUM_REGS-1:0]  inc_vec, dec_vec;

  logic a_ready, m_ready, issue_ready;

  // Arbitration: the write port is never busy, so a lone requester is
  // always granted; on a tie the requester that did not win last goes.
  always_comb begin
    a_ready = bus.a_valid && (!bus.m_valid || last_grant_m_q);
    m_ready = bus.m_valid && (!bus.a_valid || !last_grant_m_q);
  end

  always_comb begin
    last_grant_m_d = last_grant_m_q;
    reg_write_d    = a_ready || m_ready;
    rd_d           = rd_q;
    data_d         = data_q;
    grant_m_d      = grant_m_q;
    if (m_ready) begin
      last_grant_m_d = 1'b1;
      rd_d           = bus.m_rd;
      data_d         = bus.m_data;
      grant_m_d      = 1'b1;
    end else if (a_ready) begin
      last_grant_m_d = 1'b0;
      rd_d           = bus.a_rd;
      data_d         = bus.a_data;
      grant_m_d      = 1'b0;
    end
  end

  // A full counter refuses further issues to that register.
  assign issue_ready = (cnt_q[bus.issue_rd] != CNT_MAX);

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      inc_vec[r] = bus.issue_valid && issue_ready && (bus.issue_rd == ADDR_WIDTH'(r));
      dec_vec[r] = reg_write_q && (rd_q == ADDR_WIDTH'(r));
    end
  end

  // The decrement lands on the same edge the register file commits the
  // write, so stall drops exactly when the data is readable.
  always_comb begin
    err_d = err_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (inc_vec[r] && !dec_vec[r]) begin
        cnt_d[r] = cnt_q[r] + CNT_WIDTH'(1);
      end else if (dec_vec[r] && !inc_vec[r]) begin
        if (cnt_q[r] == '0) begin
          err_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] - CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_m_q <= 1'b1;
      reg_write_q    <= 1'b0;
      rd_q           <= '0;
      data_q         <= '0;
      grant_m_q      <= 1'b0;
      err_q          <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      last_grant_m_q <= last_grant_m_d;
      reg_write_q    <= reg_write_d;
      rd_q           <= rd_d;
      data_q         <= data_d;
      grant_m_q      <= grant_m_d;
      err_q          <= err_d;
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  assign bus.a_ready       = a_ready;
  assign bus.m_ready       = m_ready;
  assign bus.issue_ready   = issue_ready;
  assign bus.stall         = bus.decode_valid &&
                             ((cnt_q[bus.rs] != '0) || (cnt_q[bus.rt] != '0));
  assign bus.rd            = rd_q;
  assign bus.write_data    = data_q;
  assign bus.reg_write     = reg_write_q;
  assign bus.grant_m       = grant_m_q;
  assign bus.err_underflow = err_q;
  assign dbg_last_grant_m_o = last_grant_m_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter. Inputs change 1 ns after a rising
// edge; outputs are sampled either 1 ns after an input change (combinational
// paths) or 1 ns after a rising edge (registered paths).
module tb_regfile_wb_arbiter;

  logic clk;
  logic rst_n;
  logic dbg_last_grant_m;
  int   errors;
  int   checks;

  regfile_wb_if #(.DATA_WIDTH(16), .ADDR_WIDTH(2)) bus ();

  regfile_wb_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .CNT_WIDTH(2)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .bus                (bus),
    .dbg_last_grant_m_o (dbg_last_grant_m)
  );

  // Clock / reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver helpers.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [1:0] rd, input logic [15:0] wd,
                        input logic gm);
    chk({tag, "_regwrite"}, 32'(bus.reg_write), 32'd1);
    chk({tag, "_rd"}, 32'(bus.rd), 32'(rd));
    chk({tag, "_wdata"}, 32'(bus.write_data), 32'(wd));
    chk({tag, "_grantm"}, 32'(bus.grant_m), 32'(gm));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.a_valid = 1'b0; bus.a_rd = '0; bus.a_data = '0;
    bus.m_valid = 1'b0; bus.m_rd = '0; bus.m_data = '0;
    bus.issue_valid = 1'b0; bus.issue_rd = '0;
    bus.decode_valid = 1'b1; bus.rs = 2'd2; bus.rt = 2'd3;

    // Reset state.
    #12;
    chk("rst_regwrite", 32'(bus.reg_write), 32'd0);
    chk("rst_rd", 32'(bus.rd), 32'd0);
    chk("rst_wdata", 32'(bus.write_data), 32'd0);
    chk("rst_grantm", 32'(bus.grant_m), 32'd0);
    chk("rst_err", 32'(bus.err_underflow), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // Single ALU write to r2 with hazard tracking.
    bus.issue_valid = 1'b1; bus.issue_rd = 2'd2;
    settle();
    chk("t2_issue_ready", 32'(bus.issue_ready), 32'd1);
    tick();
    bus.issue_valid = 1'b0;
    settle();
    chk("t2_stall_pending", 32'(bus.stall), 32'd1);
    bus.a_valid = 1'b1; bus.a_rd = 2'd2; bus.a_data = 16'd1;
    settle();
    chk("t2_a_ready", 32'(bus.a_ready), 32'd1);
    chk("t2_m_ready", 32'(bus.m_ready), 32'd0);
    tick();
    bus.a_valid = 1'b0;
    chk_wr("t2_wr", 2'd2, 16'd1, 1'b0);
    chk("t2_stall_during_wr", 32'(bus.stall), 32'd1);
    tick();
    chk("t2_regwrite_idle", 32'(bus.reg_write), 32'd0);
    chk("t2_rd_hold", 32'(bus.rd), 32'd2);
    chk("t2_wdata_hold", 32'(bus.write_data), 32'd1);
    chk("t2_stall_clear", 32'(bus.stall), 32'd0);

    // Issue r0, r1, r1, r3 for the next writes.
    bus.issue_valid = 1'b1;
    bus.issue_rd = 2'd0; tick();
    bus.issue_rd = 2'd1; tick();
    bus.issue_rd = 2'd1; tick();
    bus.issue_rd = 2'd3; tick();
    bus.issue_valid = 1'b0;

    // Lone M write to r0 sets the round-robin pointer to M.
    bus.m_valid = 1'b1; bus.m_rd = 2'd0; bus.m_data = 16'd7;
    settle();
    chk("t3_m_only_ready", 32'(bus.m_ready), 32'd1);
    chk("t3_m_only_a_ready", 32'(bus.a_ready), 32'd0);
    tick();
    bus.m_valid = 1'b0;
    chk_wr("t3_mwr", 2'd0, 16'd7, 1'b1);

    // Contention: A (r1, 3) twice and M (r3, 4) once -> A, M, A.
    bus.a_valid = 1'b1; bus.a_rd = 2'd1; bus.a_data = 16'd3;
    bus.m_valid = 1'b1; bus.m_rd = 2'd3; bus.m_data = 16'd4;
    settle();
    chk("t3_g1_a_ready", 32'(bus.a_ready), 32'd1);
    chk("t3_g1_m_ready", 32'(bus.m_ready), 32'd0);
    tick();
    chk_wr("t3_wr1", 2'd1, 16'd3, 1'b0);
    chk("t3_g2_a_ready", 32'(bus.a_ready), 32'd0);
    chk("t3_g2_m_ready", 32'(bus.m_ready), 32'd1);
    tick();
    bus.m_valid = 1'b0;
    chk_wr("t3_wr2", 2'd3, 16'd4, 1'b1);
    settle();
    chk("t3_g3_a_ready", 32'(bus.a_ready), 32'd1);
    tick();
    bus.a_valid = 1'b0;
    chk_wr("t3_wr3", 2'd1, 16'd3, 1'b0);
    tick();
    chk("t3_regwrite_idle", 32'(bus.reg_write), 32'd0);
    bus.rs = 2'd1; bus.rt = 2'd3;
    settle();
    chk("t3_stall_clear", 32'(bus.stall), 32'd0);
    chk("t3_err", 32'(bus.err_underflow), 32'd0);

    // Fill r3 to the counter limit; a fourth issue is refused.
    bus.rs = 2'd0; bus.rt = 2'd3;
    bus.issue_valid = 1'b1; bus.issue_rd = 2'd3;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t4_issue_ready_fill", 32'(bus.issue_ready), 32'd1);
      tick();
    end
    chk("t4_issue_ready_full", 32'(bus.issue_ready), 32'd0);
    tick();
    bus.issue_valid = 1'b0;
    settle();
    chk("t4_stall_full", 32'(bus.stall), 32'd1);
    bus.a_valid = 1'b1; bus.a_rd = 2'd3; bus.a_data = 16'd9;
    tick();
    chk("t4_stall_after_acc1", 32'(bus.stall), 32'd1);
    tick();
    chk("t4_issue_ready_after_retire1", 32'(bus.issue_ready), 32'd1);
    chk("t4_stall_after_retire1", 32'(bus.stall), 32'd1);
    tick();
    bus.a_valid = 1'b0;
    chk_wr("t4_wr3", 2'd3, 16'd9, 1'b0);
    chk("t4_stall_before_last", 32'(bus.stall), 32'd1);
    tick();
    chk("t4_stall_clear", 32'(bus.stall), 32'd0);

    // Simultaneous issue and retire on r0 keeps its count at 1.
    bus.issue_valid = 1'b1; bus.issue_rd = 2'd0;
    tick();
    bus.issue_valid = 1'b0;
    bus.rs = 2'd0; bus.rt = 2'd0;
    bus.a_valid = 1'b1; bus.a_rd = 2'd0; bus.a_data = 16'h0011;
    tick();
    bus.a_valid = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_rd = 2'd0;
    chk_wr("t5_wr", 2'd0, 16'h0011, 1'b0);
    tick();
    bus.issue_valid = 1'b0;
    settle();
    chk("t5_stall_kept", 32'(bus.stall), 32'd1);
    bus.a_valid = 1'b1; bus.a_rd = 2'd0; bus.a_data = 16'h0022;
    tick();
    bus.a_valid = 1'b0;
    tick();
    chk("t5_stall_clear", 32'(bus.stall), 32'd0);
    chk("t5_err", 32'(bus.err_underflow), 32'd0);

    // Underflow: M retires to r1 with no pending write.
    bus.m_valid = 1'b1; bus.m_rd = 2'd1; bus.m_data = 16'd5;
    tick();
    bus.m_valid = 1'b0;
    chk("t6_err_before_commit", 32'(bus.err_underflow), 32'd0);
    tick();
    chk("t6_err_set", 32'(bus.err_underflow), 32'd1);
    tick();
    tick();
    chk("t6_err_sticky", 32'(bus.err_underflow), 32'd1);

    // Reset mid-stream with a write pending on the port.
    bus.issue_valid = 1'b1; bus.issue_rd = 2'd2;
    tick();
    bus.issue_valid = 1'b0;
    bus.rs = 2'd2; bus.rt = 2'd2;
    bus.a_valid = 1'b1; bus.a_rd = 2'd2; bus.a_data = 16'hBEEF;
    tick();
    bus.a_valid = 1'b0;
    chk_wr("t7_wr_pending", 2'd2, 16'hBEEF, 1'b0);
    rst_n = 1'b0;
    settle();
    chk("t7_rst_regwrite", 32'(bus.reg_write), 32'd0);
    chk("t7_rst_rd", 32'(bus.rd), 32'd0);
    chk("t7_rst_wdata", 32'(bus.write_data), 32'd0);
    chk("t7_rst_err", 32'(bus.err_underflow), 32'd0);
    chk("t7_rst_stall", 32'(bus.stall), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t7_post_rst_regwrite", 32'(bus.reg_write), 32'd0);

    // After reset A wins the first tie.
    bus.a_valid = 1'b1; bus.a_rd = 2'd1; bus.a_data = 16'd1;
    bus.m_valid = 1'b1; bus.m_rd = 2'd2; bus.m_data = 16'd2;
    settle();
    chk("t7_tie_a_ready", 32'(bus.a_ready), 32'd1);
    chk("t7_tie_m_ready", 32'(bus.m_ready), 32'd0);
    bus.a_valid = 1'b0;
    bus.m_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Single-write-port scheduler for the 4 x 16-bit CPU register file (RS/RT read ports, RD/WriteData/RegWrite write port).
- Arbitrates round-robin between two write-back requesters, the ALU (A) and memory-load (M), and drives the register-file write port from a register.
- Keeps a per-register pending-write scoreboard, fed by the issue stage, and raises Stall to decode on read-after-write hazards.

Parameters:
DATA_WIDTH, 16, register data width
ADDR_WIDTH, 2, register address width; NUM_REGS = 2**ADDR_WIDTH
CNT_WIDTH, 2, scoreboard counter width per register; max outstanding writes per register = 2**CNT_WIDTH-1

Ports:
Clock  in  1  single clock, rising edge
Reset  in  1  asynchronous, active-low reset
A_Valid  in  1  ALU write-back request
A_Rd  in  ADDR_WIDTH  ALU destination register
A_Data  in  DATA_WIDTH  ALU result
A_Ready  out  1  ALU request accepted this cycle
M_Valid  in  1  load write-back request
M_Rd  in  ADDR_WIDTH  load destination register
M_Data  in  DATA_WIDTH  load data
M_Ready  out  1  load request accepted this cycle
IssueValid  in  1  instruction issued with a register destination
IssueRd  in  ADDR_WIDTH  destination of issued instruction
IssueReady  out  1  scoreboard can record IssueRd
DecodeValid  in  1  decode stage holds a valid instruction
RS  in  ADDR_WIDTH  decode source 1
RT  in  ADDR_WIDTH  decode source 2
Stall  out  1  hazard on RS or RT
RD  out  ADDR_WIDTH  register-file write address
WriteData  out  DATA_WIDTH  register-file write data
RegWrite  out  1  register-file write enable
GrantM  out  1  registered; 1 = current write came from M
ErrUnderflow  out  1  sticky; write retired to a register with count 0

Behaviour:
- Reset (Reset=0, async):
  - RD=0, WriteData=0, RegWrite=0, GrantM=0, ErrUnderflow=0.
  - All scoreboard counters = 0.
  - LastGrant = M, so A wins the first tie.
- Arbitration (combinational):
  - Only A_Valid -> A_Ready=1. Only M_Valid -> M_Ready=1.
  - Both valid -> grant the requester that is not LastGrant. LastGrant updates on every accepted grant.
  - At most one Ready is high per cycle.
  - The write port is never busy, so Ready depends only on the Valids. Requesters must not make Valid depend on Ready.
  - Handshake completes when Valid and Ready are both high. A non-granted requester holds Rd/Data stable until accepted.
- Write port latency:
  - Request accepted at edge N -> RegWrite=1 with RD/WriteData = accepted Rd/Data during cycle N+1. The register file writes at edge N+1.
  - No accept in a cycle -> RegWrite=0 the next cycle; RD/WriteData hold their previous values.
  - Back-to-back accepts give back-to-back RegWrite pulses (100% throughput).
- Scoreboard, per register r, counter Cnt[r]:
  - Inc[r] = IssueValid && IssueReady && IssueRd==r.
  - Dec[r] = RegWrite && RD==r. Decrement happens at the edge where the register file commits the write.
  - Inc and Dec both set -> Cnt unchanged.
  - Dec with Cnt==0 and no Inc -> Cnt stays 0 and ErrUnderflow sets (sticky until reset).
  - IssueReady = (Cnt[IssueRd] != 2**CNT_WIDTH-1), combinational. When IssueReady=0 the issue is ignored and Cnt is not incremented.
- Hazard:
  - Stall = DecodeValid && (Cnt[RS]!=0 || Cnt[RT]!=0), combinational from current counters.
  - Stall drops in the cycle after the final retiring RegWrite edge, when the data is already in the register file.
  - RS==RT is handled naturally (no double counting).
- Same-destination requests from A and M in one cycle: both are serviced, in round-robin order, in consecutive cycles. Each retire decrements once.
- Reset mid-operation: all in-flight requests, the pending write and the scoreboard are discarded immediately. RegWrite drops asynchronously.

Test Plan:
- Reset -> RegWrite=0, Stall=0 for DecodeValid=1, RS=2, RT=3; IssueReady=1; ErrUnderflow=0.
- IssueRd=2 issued, then A_Valid, A_Rd=2, A_Data=16'd1 -> A_Ready=1. Next cycle RD=2, WriteData=1, RegWrite=1. Stall high for RS=2 until the cycle after that edge, then 0.
- A_Valid and M_Valid together for 3 cycles (A_Rd=1, M_Rd=3, M_Data=16'd4), both held until accepted -> grants A, M, A. RegWrite sequence RD=1, 3, 1. GrantM=0, 1, 0.
- Three issues to register 3 with no retires -> Cnt=3, IssueReady=0 for IssueRd=3. A fourth issue is ignored. Three retires are needed to clear Stall on RT=3.
- IssueRd=0 issued in the same cycle RegWrite retires RD=0 with Cnt[0]=1 -> Cnt[0] stays 1; Stall on RS=0 stays high.
- M write retires to register 1 with Cnt[1]=0 -> ErrUnderflow=1 and stays 1. Reset pulse mid-stream -> all outputs to reset values immediately.
